// File: rtl/frame_capture.sv
// frame_capture: turns the (x, y, colour, plot) pixel stream for the 160x120,
// 3-bit-colour screen back into linear writes on a single-port 19200x3 RAM
// (address = y*160 + x). Outside a capture the readback address rd_addr is
// forwarded to the RAM instead.
// Optional build macro FRAME_CAPTURE_CLEAR_EN: every arm first zero-fills the
// whole RAM (CLEAR state) before capture begins.
module frame_capture (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        abort,
   input  logic        plot,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [2:0]  colour,
   input  logic [14:0] rd_addr,
   output logic [14:0] ram_address,
   output logic [2:0]  ram_data,
   output logic        ram_wren,
   output logic        busy,
   output logic        done,
   output logic [14:0] pixel_count,
   output logic        dropped
);

   localparam logic [7:0]  WIDTH      = 8'd160;
   localparam logic [6:0]  HEIGHT     = 7'd120;
   localparam logic [14:0] LAST_ADDR  = 15'd19199;
   localparam logic [14:0] NUM_PIXELS = 15'd19200;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLEAR   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state;

   // Stage 1: the pixel as presented on the previous edge.
   logic        s1_plot;
   logic [7:0]  s1_x;
   logic [6:0]  s1_y;
   logic [2:0]  s1_colour;

   logic        s1_in_range;
   logic [14:0] s1_addr;

`ifdef FRAME_CAPTURE_CLEAR_EN
   logic [14:0] clr_cnt;
`endif

   // Bounds check and linear address of the stage-1 pixel; y*160 = y*128 + y*32.
   always_comb begin
      // NOTE: every signal of a combinational block is assigned on every path,
      // otherwise the tool has to remember the old value and infers a latch.
      s1_in_range = (s1_x < WIDTH) && (s1_y < HEIGHT);
      s1_addr     = ({8'd0, s1_y} << 7) + ({8'd0, s1_y} << 5) + {7'd0, s1_x};
   end

   // Both status flags are straight decodes of the state register.
   assign busy = (state == CLEAR) || (state == CAPTURE);
   assign done = (state == DONE);

   // Control FSM, pixel pipeline, RAM port registers and capture statistics.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // in this block sees the pre-edge value of every other register.
      if (!rst) begin
         state       <= IDLE;
         s1_plot     <= 1'b0;
         s1_x        <= '0;
         s1_y        <= '0;
         s1_colour   <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
         pixel_count <= '0;
         dropped     <= 1'b0;
`ifdef FRAME_CAPTURE_CLEAR_EN
         clr_cnt     <= '0;
`endif
      end else if (abort) begin
         // Cancel wins over everything; statistics of the cancelled run hold.
         state    <= IDLE;
         ram_wren <= 1'b0;
         s1_plot  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               ram_wren    <= 1'b0;
               ram_address <= rd_addr;
               s1_plot     <= 1'b0;
               if (arm) begin
                  pixel_count <= '0;
                  dropped     <= 1'b0;
`ifdef FRAME_CAPTURE_CLEAR_EN
                  clr_cnt     <= '0;
                  state       <= CLEAR;
`else
                  state       <= CAPTURE;
`endif
               end
            end
`ifdef FRAME_CAPTURE_CLEAR_EN
            CLEAR: begin
               // Zero-fill one address per cycle; incoming plots are ignored.
               ram_address <= clr_cnt;
               ram_data    <= '0;
               ram_wren    <= 1'b1;
               s1_plot     <= 1'b0;
               if (clr_cnt == LAST_ADDR) begin
                  state <= CAPTURE;
               end else begin
                  clr_cnt <= clr_cnt + 15'd1;
               end
            end
`endif
            CAPTURE: begin
               s1_plot   <= plot;
               s1_x      <= x;
               s1_y      <= y;
               s1_colour <= colour;
               if (s1_plot && s1_in_range) begin
                  ram_address <= s1_addr;
                  ram_data    <= s1_colour;
                  ram_wren    <= 1'b1;
                  if (pixel_count != NUM_PIXELS) begin
                     pixel_count <= pixel_count + 15'd1;
                  end
                  // Writing the last pixel closes the frame; this write still goes out.
                  if (s1_addr == LAST_ADDR) begin
                     state   <= DONE;
                     s1_plot <= 1'b0;
                  end
               end else begin
                  ram_wren <= 1'b0;
                  if (s1_plot) begin
                     dropped <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               ram_wren <= 1'b0;
               s1_plot  <= 1'b0;
            end
         endcase
      end
   end

endmodule
